// File: rtl/fifo_read_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_read_ctrl
//   Drain stage that sits directly after a dual-clock fifo, in the fifo's
//   read-clock domain. It pops the fifo whenever there is room downstream and
//   absorbs the fifo's one-cycle read latency. Popped words are held in a
//   two-entry skid buffer and presented on a valid/ready stream. The block
//   also keeps a saturating count of delivered words.
//
// Ports
//   clock        in   read-domain clock (the fifo read clock)
//   reset        in   synchronous active-low reset
//   enable       in   1 = allowed to pop the fifo
//   fifo_empty   in   fifo empty flag
//   q            in   fifo read data, valid the cycle after read_enable
//   read_enable  out  pop request to the fifo
//   out_data     out  head word of the skid buffer
//   out_valid    out  out_data holds a valid word
//   out_ready    in   consumer accepts the word when out_valid && out_ready
//   word_count   out  words delivered since reset, saturating
//   busy         out  words in flight or buffered, or controller running
// ---------------------------------------------------------------------------
module fifo_read_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int COUNT_W    = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] q,
    output logic                  read_enable,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [COUNT_W-1:0]    word_count,
    output logic                  busy
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                  state_r;
    state_t                  state_next_s;
    logic                    inflight_r;
    logic [1:0]              occ_r;
    logic [DATA_WIDTH-1:0]   head_r;
    logic [DATA_WIDTH-1:0]   tail_r;
    logic [COUNT_W-1:0]      count_r;
    logic                    pop_s;
    logic                    issue_s;
    logic [2:0]              load_s;

    // Consumer handshake; occupancy is never below 1 when pop is true.
    assign pop_s  = (occ_r != 2'd0) && out_ready;

    // Words the buffer will be holding once the current in-flight word lands
    // and the current pop leaves. A new read is only safe if this is below 2.
    assign load_s = {1'b0, occ_r} + {2'b00, inflight_r} - {2'b00, pop_s};

    assign issue_s     = (state_r == RUN) && !fifo_empty && (load_s < 3'd2);
    assign read_enable = issue_s;

    assign out_valid  = (occ_r != 2'd0);
    assign out_data   = head_r;
    assign word_count = count_r;
    assign busy       = inflight_r || (occ_r != 2'd0) || (state_r == RUN);

    // Controller state register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: the controller simply follows enable.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (enable) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RUN;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Marks that q carries a freshly read word in the next cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= issue_s;
        end
    end

    // Two-entry skid buffer: head_r is presented, tail_r is the second word.
    always_ff @(posedge clock) begin
        if (!reset) begin
            occ_r  <= 2'd0;
            head_r <= {DATA_WIDTH{1'b0}};
            tail_r <= {DATA_WIDTH{1'b0}};
        end else begin
            case ({inflight_r, pop_s})
                2'b10: begin
                    if (occ_r == 2'd0) begin
                        head_r <= q;
                        occ_r  <= 2'd1;
                    end else if (occ_r == 2'd1) begin
                        tail_r <= q;
                        occ_r  <= 2'd2;
                    end else begin
                        occ_r  <= occ_r;
                    end
                end
                2'b01: begin
                    head_r <= tail_r;
                    occ_r  <= occ_r - 2'd1;
                end
                2'b11: begin
                    // Write and pop together: occupancy unchanged, no bubble.
                    if (occ_r == 2'd1) begin
                        head_r <= q;
                    end else begin
                        head_r <= tail_r;
                        tail_r <= q;
                    end
                end
                default: begin
                    occ_r <= occ_r;
                end
            endcase
        end
    end

    // Delivered-word counter, sticks at all-ones instead of wrapping.
    always_ff @(posedge clock) begin
        if (!reset) begin
            count_r <= {COUNT_W{1'b0}};
        end else if (pop_s && (count_r != {COUNT_W{1'b1}})) begin
            count_r <= count_r + {{(COUNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
module tb_fifo_read_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        fifo_empty;
    logic [31:0] q;
    logic        read_enable;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] word_count;
    logic        busy;

    logic        read_enable2;
    logic [31:0] out_data2;
    logic        out_valid2;
    logic [1:0]  word_count2;
    logic        busy2;

    always #5 clock = ~clock;

    fifo_read_ctrl #(.DATA_WIDTH(32), .COUNT_W(16)) dut (
        .clock(clock), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
        .q(q), .read_enable(read_enable), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .word_count(word_count), .busy(busy)
    );

    fifo_read_ctrl #(.DATA_WIDTH(32), .COUNT_W(2)) dut2 (
        .clock(clock), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
        .q(q), .read_enable(read_enable2), .out_data(out_data2),
        .out_valid(out_valid2), .out_ready(out_ready),
        .word_count(word_count2), .busy(busy2)
    );

    // Reference model: fifo contents, words buffered downstream, the word
    // travelling on q, whether the controller is running, delivered count.
    logic [31:0] fifo_m[$];
    logic [31:0] buf_m[$];
    bit          infl_m;
    bit          qvalid_m;
    logic [31:0] qword_m;
    bit          run_m;
    int          cnt_m;
    int          rd_obs;
    int          checks;
    int          errors;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check outputs against the model, advance.
    task automatic step(input bit rst_v, input bit en_v, input bit rdy_v);
        bit          pop_e;
        bit          iss_e;
        int          load;
        logic [31:0] w;
        @(negedge clock);
        reset      = rst_v;
        enable     = en_v;
        out_ready  = rdy_v;
        fifo_empty = (fifo_m.size() == 0);
        q          = qvalid_m ? qword_m : $urandom();
        #1;
        pop_e = (buf_m.size() != 0) && rdy_v;
        load  = buf_m.size() + int'(infl_m) - int'(pop_e);
        iss_e = run_m && (fifo_m.size() != 0) && (load < 2);
        chk("read_enable", {63'd0, read_enable}, {63'd0, iss_e});
        chk("out_valid", {63'd0, out_valid}, {63'd0, buf_m.size() != 0});
        chk("busy", {63'd0, busy}, {63'd0, infl_m || (buf_m.size() != 0) || run_m});
        chk("word_count", {48'd0, word_count}, 64'(cnt_m));
        chk("word_count_sat2", {62'd0, word_count2}, 64'((cnt_m > 3) ? 3 : cnt_m));
        if (buf_m.size() != 0) begin
            chk("out_data", {32'd0, out_data}, {32'd0, buf_m[0]});
        end
        if (read_enable === 1'b1) rd_obs++;
        @(posedge clock);
        w = 32'd0;
        if (iss_e) w = fifo_m.pop_front();
        if (!rst_v) begin
            buf_m.delete();
            infl_m = 1'b0;
            run_m  = 1'b0;
            cnt_m  = 0;
        end else begin
            if (pop_e) begin
                void'(buf_m.pop_front());
                if (cnt_m < 65535) cnt_m++;
            end
            if (infl_m) buf_m.push_back(qword_m);
            infl_m = iss_e;
            run_m  = en_v;
        end
        qvalid_m = iss_e;
        if (iss_e) qword_m = w;
    endtask

    initial begin
        checks = 0; errors = 0; rd_obs = 0;
        infl_m = 1'b0; qvalid_m = 1'b0; qword_m = 32'd0; run_m = 1'b0; cnt_m = 0;
        reset = 1'b0; enable = 1'b1; out_ready = 1'b1; fifo_empty = 1'b0; q = 32'd0;
        fifo_m.push_back(32'd2); fifo_m.push_back(32'd3); fifo_m.push_back(32'd4);
        @(posedge clock);

        // 1: reset held with a non-empty fifo and enable high.
        repeat (3) step(1'b0, 1'b1, 1'b1);
        #1;
        chk("reset_out_data", {32'd0, out_data}, 64'd0);
        chk("reset_read_enable", {63'd0, read_enable}, 64'd0);

        // 2: fifo holds 2,3,4, consumer always ready.
        rd_obs = 0;
        repeat (8) step(1'b1, 1'b1, 1'b1);
        chk("t2_reads", 64'(rd_obs), 64'd3);
        chk("t2_count", {48'd0, word_count}, 64'd3);
        chk("t2_count_sat", {62'd0, word_count2}, 64'd3);

        // 3: fifo holds 5..9, consumer stalled, then released.
        for (int i = 5; i <= 9; i++) fifo_m.push_back(32'(i));
        rd_obs = 0;
        repeat (6) step(1'b1, 1'b1, 1'b0);
        chk("t3_reads_stalled", 64'(rd_obs), 64'd2);
        #1;
        chk("t3_head_held", {32'd0, out_data}, 64'd5);
        repeat (10) step(1'b1, 1'b1, 1'b1);
        chk("t3_count", {48'd0, word_count}, 64'd8);
        chk("t3_count_sat", {62'd0, word_count2}, 64'd3);

        // 4: enable drops the cycle after a read is issued.
        fifo_m.push_back(32'd10); fifo_m.push_back(32'd11); fifo_m.push_back(32'd12);
        rd_obs = 0;
        step(1'b1, 1'b1, 1'b1);
        repeat (6) step(1'b1, 1'b0, 1'b1);
        chk("t4_reads", 64'(rd_obs), 64'd2);
        chk("t4_count", {48'd0, word_count}, 64'd10);
        #1;
        chk("t4_busy_idle", {63'd0, busy}, 64'd0);

        // 5: reset while words are buffered and one is in flight.
        fifo_m.delete();
        for (int i = 20; i <= 25; i++) fifo_m.push_back(32'(i));
        repeat (3) step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        #1;
        chk("t5_valid_after_reset", {63'd0, out_valid}, 64'd0);
        chk("t5_count_after_reset", {48'd0, word_count}, 64'd0);
        repeat (4) step(1'b1, 1'b0, 1'b1);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            if (($urandom_range(0, 2) == 0) && (fifo_m.size() < 8)) fifo_m.push_back($urandom());
            step($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
        end
        repeat (6) step(1'b1, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
